// File: rtl/e203_exu_bjp_resolve_pkg.sv
// e203_exu_bjp_resolve_pkg: shared widths, FSM encoding and instruction-length constants
package e203_exu_bjp_resolve_pkg;
    localparam int E203_PC_SIZE = 32;
    localparam logic [2:0] LEN16 = 3'd2;
    localparam logic [2:0] LEN32 = 3'd4;
    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} bjp_state_e;
endpackage

// File: rtl/e203_exu_bjp_resolve_if.sv
// e203_exu_bjp_resolve_if: commit candidate bus plus flush request/ack back to the IFU
interface e203_exu_bjp_resolve_if
    import e203_exu_bjp_resolve_pkg::*;
#(
    parameter int PC_SIZE = E203_PC_SIZE
);
    logic               cmt_i_valid;
    logic               cmt_i_ready;
    logic               cmt_i_bjp;
    logic               cmt_i_bjp_prdt;
    logic               cmt_i_bjp_rslv;
    logic               cmt_i_rv32;
    logic [PC_SIZE-1:0] cmt_i_pc;
    logic [PC_SIZE-1:0] cmt_i_bjp_tgt;
    logic               pipe_flush_req;
    logic               pipe_flush_ack;
    logic [PC_SIZE-1:0] pipe_flush_pc;
    modport master (
        output cmt_i_valid, cmt_i_bjp, cmt_i_bjp_prdt, cmt_i_bjp_rslv, cmt_i_rv32,
               cmt_i_pc, cmt_i_bjp_tgt, pipe_flush_ack,
        input  cmt_i_ready, pipe_flush_req, pipe_flush_pc
    );
    modport slave (
        input  cmt_i_valid, cmt_i_bjp, cmt_i_bjp_prdt, cmt_i_bjp_rslv, cmt_i_rv32,
               cmt_i_pc, cmt_i_bjp_tgt, pipe_flush_ack,
        output cmt_i_ready, pipe_flush_req, pipe_flush_pc
    );
endinterface

// File: rtl/e203_exu_bjp_resolve_sat_cnt.sv
// e203_sat_cnt: saturating up-counter with synchronous clear taking priority over increment
module e203_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !(&cnt)) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/e203_exu_bjp_resolve.sv
// e203_exu_bjp_resolve: resolves committed branches against the IFU prediction,
// raises a held redirect on mispredict and keeps branch/mispredict statistics.
module e203_exu_bjp_resolve
    import e203_exu_bjp_resolve_pkg::*;
#(
    parameter int PC_SIZE = E203_PC_SIZE,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    e203_exu_bjp_resolve_if.slave bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     bjp_cnt,
    output logic [CNT_W-1:0]     mis_cnt
);
    bjp_state_e         state, nxt_state;
    logic [PC_SIZE-1:0] flush_pc, redirect_pc;
    logic               ready, mis, bjp_acc, mis_acc;

    assign ready       = (state == IDLE);
    assign mis         = bus.cmt_i_valid & bus.cmt_i_bjp & (bus.cmt_i_bjp_prdt ^ bus.cmt_i_bjp_rslv);
    assign bjp_acc     = bus.cmt_i_valid & ready & bus.cmt_i_bjp;
    assign mis_acc     = mis & ready;
    assign redirect_pc = bus.cmt_i_bjp_rslv ? bus.cmt_i_bjp_tgt
                       : bus.cmt_i_pc + PC_SIZE'(bus.cmt_i_rv32 ? LEN32 : LEN16);

    always_comb begin
        nxt_state = state;
        if (state == IDLE && mis) nxt_state = FLUSH;
        if (state == FLUSH && bus.pipe_flush_ack) nxt_state = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt_state;
    end

    // Redirect target is captured only on an accepted mispredict, so it stays put through FLUSH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flush_pc <= '0;
        else if (mis_acc) flush_pc <= redirect_pc;
    end

    assign bus.cmt_i_ready    = ready;
    assign bus.pipe_flush_req = (state == FLUSH);
    assign bus.pipe_flush_pc  = flush_pc;

    e203_sat_cnt #(.W(CNT_W)) u_bjp_cnt (
        .clk(clk), .rst_n(rst_n), .en(bjp_acc), .clr(cnt_clr), .cnt(bjp_cnt)
    );
    e203_sat_cnt #(.W(CNT_W)) u_mis_cnt (
        .clk(clk), .rst_n(rst_n), .en(mis_acc), .clr(cnt_clr), .cnt(mis_cnt)
    );
endmodule

// File: tb/tb_e203_exu_bjp_resolve.sv
// tb_e203_exu_bjp_resolve: randomized and directed scoreboard bench for the branch resolve unit
module tb_e203_exu_bjp_resolve;
    localparam int CNT_W = 6;
    localparam longint CMAX = (64'd1 << CNT_W) - 1;

    typedef struct {
        logic        req;
        logic        ready;
        logic [31:0] pc;
        longint      b;
        longint      m;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cnt_clr = 1'b0;
    logic [CNT_W-1:0] bjp_cnt, mis_cnt;
    int checks = 0;
    int passes = 0;
    exp_t q[$];

    logic        m_flush;
    logic [31:0] m_pc;
    longint      m_b, m_m;

    e203_exu_bjp_resolve_if #(.PC_SIZE(32)) bus ();

    e203_exu_bjp_resolve #(.PC_SIZE(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .cnt_clr(cnt_clr), .bjp_cnt(bjp_cnt), .mis_cnt(mis_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(logic v, logic bjp, logic prdt, logic rslv, logic rv32,
                         logic [31:0] pc, logic [31:0] tgt, logic ack, logic clr);
        bus.cmt_i_valid    = v;
        bus.cmt_i_bjp      = bjp;
        bus.cmt_i_bjp_prdt = prdt;
        bus.cmt_i_bjp_rslv = rslv;
        bus.cmt_i_rv32     = rv32;
        bus.cmt_i_pc       = pc;
        bus.cmt_i_bjp_tgt  = tgt;
        bus.pipe_flush_ack = ack;
        cnt_clr            = clr;
    endtask

    function automatic longint sat_inc(longint x);
        return (x < CMAX) ? x + 1 : x;
    endfunction

    task automatic model_reset();
        m_flush = 1'b0;
        m_pc = '0;
        m_b = 0;
        m_m = 0;
    endtask

    // Reference: a commit is taken only outside a flush; a mispredict opens a flush until acked
    task automatic step();
        logic        acc, mis;
        logic [32:0] sum;
        exp_t        e;
        @(posedge clk);
        acc = !m_flush && bus.cmt_i_valid;
        mis = bus.cmt_i_valid && bus.cmt_i_bjp && (bus.cmt_i_bjp_prdt != bus.cmt_i_bjp_rslv);
        if (cnt_clr) begin
            m_b = 0;
            m_m = 0;
        end else begin
            if (acc && bus.cmt_i_bjp) m_b = sat_inc(m_b);
            if (acc && mis) m_m = sat_inc(m_m);
        end
        if (m_flush) begin
            if (bus.pipe_flush_ack) m_flush = 1'b0;
        end else if (mis) begin
            m_flush = 1'b1;
            sum = {1'b0, bus.cmt_i_pc} + (bus.cmt_i_rv32 ? 33'd4 : 33'd2);
            m_pc = bus.cmt_i_bjp_rslv ? bus.cmt_i_bjp_tgt : sum[31:0];
        end
        e.req = m_flush;
        e.ready = !m_flush;
        e.pc = m_pc;
        e.b = m_b;
        e.m = m_m;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("flush_req", 64'(bus.pipe_flush_req), 64'(e.req));
                chk("cmt_ready", 64'(bus.cmt_i_ready), 64'(e.ready));
                chk("flush_pc", 64'(bus.pipe_flush_pc), 64'(e.pc));
                chk("bjp_cnt", 64'(bjp_cnt), 64'(e.b));
                chk("mis_cnt", 64'(mis_cnt), 64'(e.m));
            end
        end
    end

    initial begin : stim
        drive(0, 0, 0, 0, 0, '0, '0, 0, 0);
        model_reset();
        #1;
        chk("rst_req", 64'(bus.pipe_flush_req), 64'd0);
        chk("rst_ready", 64'(bus.cmt_i_ready), 64'd1);
        chk("rst_pc", 64'(bus.pipe_flush_pc), 64'd0);
        chk("rst_bjp_cnt", 64'(bjp_cnt), 64'd0);
        chk("rst_mis_cnt", 64'(mis_cnt), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // correctly predicted backward branch
        drive(1, 1, 1, 1, 1, 32'h8000_0100, 32'h8000_00C0, 0, 0); step();
        // not-taken mispredict, ack arrives three cycles into FLUSH
        drive(1, 1, 1, 0, 1, 32'h8000_0200, 32'h8000_0300, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, 1, 32'h8000_0400, 32'h8000_0500, 0, 0); step();
        end
        drive(1, 1, 1, 0, 1, 32'h8000_0600, 32'h8000_0700, 1, 0); step();
        drive(0, 0, 0, 0, 0, '0, '0, 0, 0); step();
        // taken mispredict with ack in the first FLUSH cycle
        drive(1, 1, 0, 1, 1, 32'h8000_0800, 32'h8000_0040, 0, 0); step();
        drive(0, 0, 0, 0, 0, '0, '0, 1, 0); step();
        drive(0, 0, 0, 0, 0, '0, '0, 1, 0); step();
        // 16-bit fall-through wraps to zero
        drive(1, 1, 1, 0, 0, 32'hFFFF_FFFE, 32'h1234_5678, 0, 0); step();
        drive(0, 0, 0, 0, 0, '0, '0, 1, 0); step();
        // non-bjp with disagreeing predict bits never flushes
        drive(1, 0, 1, 0, 1, 32'h8000_0900, 32'h8000_0A00, 0, 0); step();
        // drive both counters into saturation
        for (int i = 0; i < 70; i++) begin
            drive(1, 1, 1, 0, 1, 32'h8000_1000 + 32'(i * 4), 32'h0, 0, 0); step();
            drive(1, 1, 1, 1, 1, 32'h8000_2000, 32'h8000_3000, 1, 0); step();
            drive(1, 1, 0, 0, 1, 32'h8000_2000, 32'h8000_3000, 0, 0); step();
        end
        // clear wins over a same-cycle mispredict commit
        drive(1, 1, 0, 1, 0, 32'h8000_4000, 32'h8000_5000, 0, 1); step();
        drive(0, 0, 0, 0, 0, '0, '0, 1, 0); step();
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), {$urandom()} & 32'hFFFF_FFFE, {$urandom()} & 32'hFFFF_FFFE,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
            step();
        end
        // async reset in the middle of a flush
        drive(0, 0, 0, 0, 0, '0, '0, 1, 0); step();
        drive(1, 1, 1, 0, 1, 32'h8000_6000, 32'h0, 0, 0); step();
        drive(0, 0, 0, 0, 0, '0, '0, 0, 0);
        #1;
        chk("pre_rst_req", 64'(bus.pipe_flush_req), 64'd1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_req", 64'(bus.pipe_flush_req), 64'd0);
        chk("async_rst_ready", 64'(bus.cmt_i_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, '0, '0, 0, 0); step();
        @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/e203_exu_bjp_resolve.md
Name: e203_exu_bjp_resolve

Overview:
- Commit-side counterpart of the IFU lite branch predictor.
- Receives resolved branch/jump results from the EXU commit point and compares them with the IFU prediction.
- On a direction mispredict, registers a redirect PC and drives a valid/ack flush handshake back to the IFU. Further commits are blocked until the IFU acknowledges.
- Keeps saturating branch and mispredict counters for CSR readout.

Parameters:
- PC_SIZE, 32, PC width (matches E203_PC_SIZE).
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmt_i_valid  in  1  commit candidate valid
- cmt_i_ready  out  1  commit accepted this cycle
- cmt_i_bjp  in  1  candidate is a JAL/JALR/Bxx
- cmt_i_bjp_prdt  in  1  IFU predicted taken
- cmt_i_bjp_rslv  in  1  EXU resolved taken
- cmt_i_rv32  in  1  1 = 32-bit instruction (length 4), 0 = 16-bit (length 2)
- cmt_i_pc  in  PC_SIZE  PC of the candidate
- cmt_i_bjp_tgt  in  PC_SIZE  resolved taken target
- pipe_flush_req  out  1  redirect request to IFU
- pipe_flush_ack  in  1  IFU accepts redirect
- pipe_flush_pc  out  PC_SIZE  redirect PC
- cnt_clr  in  1  synchronous clear of both counters
- bjp_cnt  out  CNT_W  committed branch/jump count
- mis_cnt  out  CNT_W  mispredict count

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous active-low. Reset puts the FSM in IDLE and clears pipe_flush_req, pipe_flush_pc, bjp_cnt and mis_cnt to 0. cmt_i_ready resets to 1 because it is combinational from IDLE.
- Mispredict detect: mis = cmt_i_valid & cmt_i_bjp & (cmt_i_bjp_prdt ^ cmt_i_bjp_rslv).
- Redirect PC:
  - cmt_i_bjp_rslv = 1: cmt_i_bjp_tgt.
  - cmt_i_bjp_rslv = 0: cmt_i_pc + (cmt_i_rv32 ? 4 : 2).
  - Addition is modulo 2^PC_SIZE; wrap-around is allowed.
- FSM states: IDLE, FLUSH.
- IDLE:
  - cmt_i_ready = 1, so every valid candidate commits in the same cycle.
  - If mis: the redirect PC is registered into pipe_flush_pc, and the next state is FLUSH.
  - Otherwise the FSM stays in IDLE.
- FLUSH:
  - pipe_flush_req = 1 (registered) and cmt_i_ready = 0.
  - pipe_flush_pc is held stable until the acknowledge.
  - On pipe_flush_ack = 1 the next state is IDLE and pipe_flush_req falls in the following cycle.
  - No commit is accepted in the ack cycle: the flush discards upstream wrong-path instructions.
- Latency: mispredict commit in cycle N gives pipe_flush_req = 1 in cycle N+1. Minimum FLUSH dwell is 1 cycle (ack in N+1 returns IDLE in N+2).
- pipe_flush_ack while in IDLE is ignored.
- Counters:
  - bjp_cnt increments on cmt_i_valid & cmt_i_ready & cmt_i_bjp.
  - mis_cnt increments when mis is accepted.
  - Both saturate at all-ones.
  - cnt_clr has priority over an increment in the same cycle; the counters read 0 next cycle.
- Non-bjp and correctly predicted bjp candidates never leave IDLE.
- Reset asserted during FLUSH: immediate return to IDLE with the request dropped; the pending redirect is lost.

Decomposition:
- Shared package/defines: PC_SIZE via E203_PC_SIZE, FSM state encodings (IDLE = 1'b0, FLUSH = 1'b1), instruction-length constants 2 and 4.
- One natural sub-module: e203_sat_cnt (enable, clear, saturating counter of width CNT_W), instantiated twice.
- Flops use the sirv_gnrl_dfflr style with async rst_n.

Test Plan:
- Reset, then backward Bxx with prdt = 1, rslv = 1, pc = 0x8000_0100 -> commit accepted; no flush; bjp_cnt = 1, mis_cnt = 0.
- Bxx with prdt = 1, rslv = 0, rv32 = 1, pc = 0x8000_0200 -> next cycle pipe_flush_req = 1 and pipe_flush_pc = 0x8000_0204; cmt_i_ready = 0 until 3 cycles later the ack arrives; req drops in the cycle after ack; mis_cnt = 1.
- Bxx with prdt = 0, rslv = 1, tgt = 0x8000_0040 -> pipe_flush_pc = 0x8000_0040. Ack held high in the first FLUSH cycle -> FSM back to IDLE after exactly 1 cycle.
- Bxx with prdt = 1, rslv = 0, rv32 = 0, pc = 0xFFFF_FFFE -> pipe_flush_pc = 0x0000_0000 (wrap-around).
- Force bjp_cnt to all-ones, then commit one more branch -> stays 0xFFFF_FFFF. Assert cnt_clr together with a mispredict commit -> both counters 0 next cycle.
- Assert rst_n low while in FLUSH -> pipe_flush_req = 0 immediately and cmt_i_ready = 1.
